wb_line_mem_slave: RTL

- Wishbone classic-cycle slave that answers the 128-bit line requests issued by the pipeline's ifetch and memory master ports.
- Backs a line-organised memory array; one instance per port (instruction, data).
- Programmable wait-state latency lets the pipeline be exercised under memory stall conditions.

---
 rtl/wb_line_mem_slave_if.sv | 25 ++
 rtl/wb_line_mem_slave.sv | 130 +++++++++++++
 2 files changed

// File: rtl/wb_line_mem_slave_if.sv
// Wishbone classic line-transfer bus between a pipeline master port and wb_line_mem_slave.
// Carries a 128-bit data line per transfer with 16 byte-lane selects.
interface wb_line_mem_slave_if #(
    parameter int ADDR_W = 12
);
    logic              CYC;
    logic              STB;
    logic              WE;
    logic [ADDR_W-1:0] ADR;
    logic [15:0]       SEL;
    logic [127:0]      DAT_M;
    logic [127:0]      DAT_S;
    logic              ACK;
    logic              ERR;

    modport master (
        output CYC, STB, WE, ADR, SEL, DAT_M,
        input  DAT_S, ACK, ERR
    );

    modport slave (
        input  CYC, STB, WE, ADR, SEL, DAT_M,
        output DAT_S, ACK, ERR
    );
endinterface

// File: rtl/wb_line_mem_slave.sv
// Wishbone classic slave backing a line-organised memory with programmable wait states.
// Define WB_LINE_MEM_ERR_EN to terminate out-of-range line addresses with ERR instead of wrapping.
module wb_line_mem_slave #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_LINES = 256,
    parameter int ADDR_W      = 12
) (
    input  logic               clk,
    input  logic               rst,
    wb_line_mem_slave_if.slave bus,
    output logic               busy
);
    localparam int         IDX_W = $clog2(DEPTH_LINES);
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         count_q, count_d;
    logic [IDX_W-1:0]   reqAdr_q, reqAdr_d;
    logic [15:0]        reqSel_q, reqSel_d;
    logic               reqWe_q, reqWe_d;
    logic [127:0]       reqDat_q, reqDat_d;
    logic               reqBad_q, reqBad_d;
    logic [127:0]       datS_q, datS_d;
    logic               enterResp;
    logic               adrInBad;
    logic [ADDR_W-IDX_W-1:0] unusedAdrBits;

    logic [127:0] mem [DEPTH_LINES];

    assign unusedAdrBits = bus.ADR[ADDR_W-1:IDX_W];

`ifdef WB_LINE_MEM_ERR_EN
    assign adrInBad = (bus.ADR >> IDX_W) != '0;
    assign bus.ERR  = (state_q == S_RESP) && reqBad_q;
`else
    assign adrInBad = 1'b0;
    assign bus.ERR  = 1'b0;
`endif

    assign bus.ACK   = (state_q == S_RESP) && !reqBad_q;
    assign bus.DAT_S = datS_q;
    assign busy      = (state_q != S_IDLE);

    // Read data is fetched using reqAdr_d so the zero-latency path sees the address being captured.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reqAdr_d  = reqAdr_q;
        reqSel_d  = reqSel_q;
        reqWe_d   = reqWe_q;
        reqDat_d  = reqDat_q;
        reqBad_d  = reqBad_q;
        datS_d    = datS_q;
        enterResp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.CYC && bus.STB) begin
                    reqAdr_d = bus.ADR[IDX_W-1:0];
                    reqSel_d = bus.SEL;
                    reqWe_d  = bus.WE;
                    reqDat_d = bus.DAT_M;
                    reqBad_d = adrInBad;
                    count_d  = LAT;
                    if (LAT == 4'd0) begin
                        state_d   = S_RESP;
                        enterResp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                count_d = count_q - 4'd1;
                if (!bus.CYC) begin
                    state_d = S_IDLE;
                    count_d = 4'd0;
                end else if (count_q == 4'd1) begin
                    state_d   = S_RESP;
                    enterResp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (enterResp && !reqWe_d && !reqBad_d) begin
            datS_d = mem[reqAdr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= 4'd0;
            reqAdr_q <= '0;
            reqSel_q <= 16'h0;
            reqWe_q  <= 1'b0;
            reqDat_q <= 128'h0;
            reqBad_q <= 1'b0;
            datS_q   <= 128'h0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reqAdr_q <= reqAdr_d;
            reqSel_q <= reqSel_d;
            reqWe_q  <= reqWe_d;
            reqDat_q <= reqDat_d;
            reqBad_q <= reqBad_d;
            datS_q   <= datS_d;
        end
    end

    // The array is not reset; a reset arriving during RESP suppresses the pending write.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_RESP && reqWe_q && !reqBad_q) begin
            for (int i = 0; i < 16; i++) begin
                if (reqSel_q[i]) begin
                    mem[reqAdr_q][8*i +: 8] <= reqDat_q[8*i +: 8];
                end
            end
        end
    end
endmodule
